// File: rtl/l2cache_ctrl.sv
// rtl/l2cache_ctrl.sv - two-way set-associative L2 cache controller for the L1 miss path
//
// Serves one-block (128-bit) L1 read-fill and dirty-writeback requests.
// Drives external tag/data/dirty/LRU arrays: 512 sets, 2 ways, 512-bit lines.
// On a miss it evicts the victim line if it is dirty, then fetches the whole line.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   drq, l2_cache_rw, l2_addr, l2_index, l2_wd
//                   L1 request: type 0=read 1=write, address, set, writeback block
//   l2_busy, l2_rdy, l2_rd_data, l2_complete
//                   L1 response: busy, read data valid, read data, write done
//   index           array set index (latched l2_index)
//   tag*_rd, data*_rd, dirty*, lru
//                   array read values
//   *_rw, tag_wd, data_wd, dirty_wd, lru_wd
//                   array write enables and write data
//   mem_rq, mem_rw, mem_addr, mem_wd, mem_rdy, mem_rd
//                   line-wide memory handshake
//
// Build option: defining L2_STAT_EN adds hit_cnt/miss_cnt statistics outputs.

module l2cache_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         drq,
    input  logic         l2_cache_rw,
    input  logic [31:0]  l2_addr,
    input  logic [8:0]   l2_index,
    input  logic [127:0] l2_wd,
    output logic         l2_busy,
    output logic         l2_rdy,
    output logic [127:0] l2_rd_data,
    output logic         l2_complete,
    output logic [8:0]   index,
    input  logic [17:0]  tag0_rd,
    input  logic [17:0]  tag1_rd,
    input  logic [511:0] data0_rd,
    input  logic [511:0] data1_rd,
    input  logic         dirty0,
    input  logic         dirty1,
    input  logic         lru,
    output logic         tag0_rw,
    output logic         tag1_rw,
    output logic         data0_rw,
    output logic         data1_rw,
    output logic         dirty0_rw,
    output logic         dirty1_rw,
    output logic         lru_rw,
    output logic [17:0]  tag_wd,
    output logic [511:0] data_wd,
    output logic         dirty_wd,
    output logic         lru_wd,
    output logic         mem_rq,
    output logic         mem_rw,
    output logic [31:0]  mem_addr,
    output logic [511:0] mem_wd,
    input  logic         mem_rdy,
    input  logic [511:0] mem_rd
`ifdef L2_STAT_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ACCESS   = 3'd1;
    localparam logic [2:0] S_WB_MEM   = 3'd2;
    localparam logic [2:0] S_FILL_MEM = 3'd3;
    localparam logic [2:0] S_WRITE_L2 = 3'd4;
    localparam logic [2:0] S_RESP_RD  = 3'd5;

    logic [2:0]   r_state;
    logic [31:4]  r_addr;
    logic [8:0]   r_index;
    logic         r_rw;
    logic [127:0] r_wd;
    logic         r_way;       // hit way or victim way
    logic [16:0]  r_vtag;      // victim tag for the writeback address
    logic         r_from_mem;  // line buffer holds a fetched line
    logic [511:0] r_line;

    logic         w_hit0;
    logic         w_hit1;
    logic         w_hit;
    logic         w_hitway;
    logic         w_victim;
    logic [16:0]  w_vtag;
    logic         w_vdirty;
    logic [511:0] w_line;
    logic [511:0] w_merged;
    logic [127:0] w_rd_sel;
    logic [8:0]   w_sub_lsb;
    logic         w_unused_addr;

    // Byte offset within a sub-block never matters at this level.
    assign w_unused_addr = ^l2_addr[3:0];

    assign w_hit0   = tag0_rd[17] && (tag0_rd[16:0] == r_addr[31:15]);
    assign w_hit1   = tag1_rd[17] && (tag1_rd[16:0] == r_addr[31:15]);
    assign w_hit    = w_hit0 | w_hit1;
    assign w_hitway = ~w_hit0;  // way0 wins when both match

    // Invalid ways are filled first (way0 before way1); otherwise evict the LRU way.
    assign w_victim = ~tag0_rd[17] ? 1'b0 : (~tag1_rd[17] ? 1'b1 : lru);
    assign w_vtag   = w_victim ? tag1_rd[16:0] : tag0_rd[16:0];
    assign w_vdirty = w_victim ? (tag1_rd[17] & dirty1) : (tag0_rd[17] & dirty0);

    // The data arrays read synchronously, so a hit or victim line is only valid
    // from the cycle after ACCESS. The index is stable until IDLE, so the array
    // output itself serves as the line buffer for hits and writebacks; only a
    // fetched line needs to be stored locally.
    assign w_line    = r_from_mem ? r_line : (r_way ? data1_rd : data0_rd);
    assign w_sub_lsb = {r_addr[5:4], 7'b0};
    assign w_rd_sel  = w_line[w_sub_lsb +: 128];

    always_comb begin
        w_merged = w_line;
        if (r_rw) begin
            w_merged[w_sub_lsb +: 128] = r_wd;
        end
    end

    assign index = r_index;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_index    <= '0;
            r_rw       <= 1'b0;
            r_wd       <= '0;
            r_way      <= 1'b0;
            r_vtag     <= '0;
            r_from_mem <= 1'b0;
            r_line     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (drq) begin
                        r_addr  <= l2_addr[31:4];
                        r_index <= l2_index;
                        r_rw    <= l2_cache_rw;
                        r_wd    <= l2_wd;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_from_mem <= 1'b0;
                    if (w_hit) begin
                        r_way   <= w_hitway;
                        r_state <= r_rw ? S_WRITE_L2 : S_RESP_RD;
                    end else begin
                        r_way   <= w_victim;
                        r_vtag  <= w_vtag;
                        r_state <= w_vdirty ? S_WB_MEM : S_FILL_MEM;
                    end
                end
                S_WB_MEM: begin
                    if (mem_rdy) begin
                        r_state <= S_FILL_MEM;
                    end
                end
                S_FILL_MEM: begin
                    if (mem_rdy) begin
                        r_line     <= mem_rd;
                        r_from_mem <= 1'b1;
                        r_state    <= S_WRITE_L2;
                    end
                end
                S_WRITE_L2: begin
                    r_state <= r_rw ? S_IDLE : S_RESP_RD;
                end
                S_RESP_RD: begin
                    if (!drq) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // All outputs other than index decode from the state, so every one of them
    // is zero in IDLE and therefore drops the moment reset is asserted.
    always_comb begin
        l2_busy     = (r_state != S_IDLE);
        l2_rdy      = 1'b0;
        l2_rd_data  = '0;
        l2_complete = 1'b0;
        tag0_rw     = 1'b0;
        tag1_rw     = 1'b0;
        data0_rw    = 1'b0;
        data1_rw    = 1'b0;
        dirty0_rw   = 1'b0;
        dirty1_rw   = 1'b0;
        lru_rw      = 1'b0;
        tag_wd      = '0;
        data_wd     = '0;
        dirty_wd    = 1'b0;
        lru_wd      = 1'b0;
        mem_rq      = 1'b0;
        mem_rw      = 1'b0;
        mem_addr    = '0;
        mem_wd      = '0;
        case (r_state)
            S_ACCESS: begin
                if (w_hit) begin
                    lru_rw = 1'b1;
                    lru_wd = ~w_hitway;
                end
            end
            S_WB_MEM: begin
                mem_rq   = 1'b1;
                mem_rw   = 1'b1;
                mem_addr = {r_vtag, r_index, 6'b0};
                mem_wd   = w_line;
            end
            S_FILL_MEM: begin
                mem_rq   = 1'b1;
                mem_addr = {r_addr[31:6], 6'b0};
            end
            S_WRITE_L2: begin
                tag0_rw     = ~r_way;
                tag1_rw     = r_way;
                data0_rw    = ~r_way;
                data1_rw    = r_way;
                dirty0_rw   = ~r_way;
                dirty1_rw   = r_way;
                tag_wd      = {1'b1, r_addr[31:15]};
                data_wd     = w_merged;
                dirty_wd    = r_rw;
                lru_rw      = 1'b1;
                lru_wd      = ~r_way;
                l2_complete = r_rw;
            end
            S_RESP_RD: begin
                l2_rdy     = 1'b1;
                l2_rd_data = w_rd_sel;
            end
            default: ;
        endcase
    end

`ifdef L2_STAT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_ACCESS) begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
